// File: rtl/adc_peak_detector.sv
// Windowed peak-magnitude and full-scale detector for a dual-channel packed ADC stream.
// Results are published once per window of 2**WINDOW_LOG2 valid samples.
module adc_peak_detector #(
    parameter int unsigned AXIS_DATA_SIZE = 32,
    parameter int unsigned ZMOD_DATA_SIZE = 14,
    parameter int unsigned WINDOW_LOG2    = 10
) (
    input  logic                      i_sys_clock,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic [AXIS_DATA_SIZE-1:0] i_adc_data,
    input  logic                      i_adc_data_valid,
    output logic [ZMOD_DATA_SIZE-1:0] o_ch1_peak,
    output logic [ZMOD_DATA_SIZE-1:0] o_ch2_peak,
    output logic [1:0]                o_clip,
    output logic                      o_peak_valid
);

    localparam int unsigned CNT_W   = WINDOW_LOG2 + 1;
    localparam int unsigned CH1_LSB = AXIS_DATA_SIZE - ZMOD_DATA_SIZE;
    localparam int unsigned CH2_LSB = AXIS_DATA_SIZE / 2 - ZMOD_DATA_SIZE;

    localparam logic [CNT_W-1:0]          WINDOW_LEN = CNT_W'(1) << WINDOW_LOG2;
    localparam logic [ZMOD_DATA_SIZE-1:0] POS_FULL   = {1'b0, {(ZMOD_DATA_SIZE-1){1'b1}}};
    localparam logic [ZMOD_DATA_SIZE-1:0] NEG_FULL   = {1'b1, {(ZMOD_DATA_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_REPORT  = 2'd2
    } state_e;

    state_e                    state_q,     state_d;
    logic [CNT_W-1:0]          cnt_q,       cnt_d;
    logic [ZMOD_DATA_SIZE-1:0] ch1_max_q,   ch1_max_d;
    logic [ZMOD_DATA_SIZE-1:0] ch2_max_q,   ch2_max_d;
    logic [1:0]                clip_acc_q,  clip_acc_d;
    logic [ZMOD_DATA_SIZE-1:0] ch1_peak_q,  ch1_peak_d;
    logic [ZMOD_DATA_SIZE-1:0] ch2_peak_q,  ch2_peak_d;
    logic [1:0]                clip_q,      clip_d;
    logic                      peak_valid_q, peak_valid_d;

    logic [ZMOD_DATA_SIZE-1:0] ch1_raw_c,  ch2_raw_c;
    logic [ZMOD_DATA_SIZE-1:0] ch1_abs_c,  ch2_abs_c;
    logic [1:0]                samp_clip_c;
    logic                      seed_c;
    logic [CNT_W-1:0]          base_cnt_c,  fold_cnt_c;
    logic [ZMOD_DATA_SIZE-1:0] base_ch1_c,  fold_ch1_c;
    logic [ZMOD_DATA_SIZE-1:0] base_ch2_c,  fold_ch2_c;
    logic [1:0]                base_clip_c, fold_clip_c;
    logic                      unused_bits_c;

    // Magnitude in the sample width; the most negative code maps to 2**(W-1) without overflow.
    function automatic logic [ZMOD_DATA_SIZE-1:0] abs_mag(input logic [ZMOD_DATA_SIZE-1:0] x);
        return x[ZMOD_DATA_SIZE-1] ? (~x + ZMOD_DATA_SIZE'(1)) : x;
    endfunction

    assign ch1_raw_c = i_adc_data[CH1_LSB +: ZMOD_DATA_SIZE];
    assign ch2_raw_c = i_adc_data[CH2_LSB +: ZMOD_DATA_SIZE];
    // Spare bus bits carry no sample data and are deliberately ignored.
    assign unused_bits_c = ^i_adc_data;

    assign ch1_abs_c      = abs_mag(ch1_raw_c);
    assign ch2_abs_c      = abs_mag(ch2_raw_c);
    assign samp_clip_c[0] = (ch1_raw_c == POS_FULL) || (ch1_raw_c == NEG_FULL);
    assign samp_clip_c[1] = (ch2_raw_c == POS_FULL) || (ch2_raw_c == NEG_FULL);

    // Outside ACQUIRE a new window starts from empty accumulators (seeding from the REPORT cycle).
    assign seed_c      = (state_q != ST_ACQUIRE);
    assign base_cnt_c  = seed_c ? '0 : cnt_q;
    assign base_ch1_c  = seed_c ? '0 : ch1_max_q;
    assign base_ch2_c  = seed_c ? '0 : ch2_max_q;
    assign base_clip_c = seed_c ? '0 : clip_acc_q;

    assign fold_cnt_c  = base_cnt_c + CNT_W'(1);
    assign fold_ch1_c  = (ch1_abs_c > base_ch1_c) ? ch1_abs_c : base_ch1_c;
    assign fold_ch2_c  = (ch2_abs_c > base_ch2_c) ? ch2_abs_c : base_ch2_c;
    assign fold_clip_c = base_clip_c | samp_clip_c;

    always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ch1_max_q    <= '0;
            ch2_max_q    <= '0;
            clip_acc_q   <= '0;
            ch1_peak_q   <= '0;
            ch2_peak_q   <= '0;
            clip_q       <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch1_max_q    <= ch1_max_d;
            ch2_max_q    <= ch2_max_d;
            clip_acc_q   <= clip_acc_d;
            ch1_peak_q   <= ch1_peak_d;
            ch2_peak_q   <= ch2_peak_d;
            clip_q       <= clip_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch1_max_d    = ch1_max_q;
        ch2_max_d    = ch2_max_q;
        clip_acc_d   = clip_acc_q;
        ch1_peak_d   = ch1_peak_q;
        ch2_peak_d   = ch2_peak_q;
        clip_d       = clip_q;
        peak_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d    = ST_ACQUIRE;
                    cnt_d      = '0;
                    ch1_max_d  = '0;
                    ch2_max_d  = '0;
                    clip_acc_d = '0;
                end
            end
            ST_ACQUIRE, ST_REPORT: begin
                if (!i_enable) begin
                    // Abort: partial window is dropped, published results stay untouched.
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    ch1_max_d  = '0;
                    ch2_max_d  = '0;
                    clip_acc_d = '0;
                end else begin
                    state_d    = ST_ACQUIRE;
                    cnt_d      = base_cnt_c;
                    ch1_max_d  = base_ch1_c;
                    ch2_max_d  = base_ch2_c;
                    clip_acc_d = base_clip_c;
                    if (i_adc_data_valid) begin
                        cnt_d      = fold_cnt_c;
                        ch1_max_d  = fold_ch1_c;
                        ch2_max_d  = fold_ch2_c;
                        clip_acc_d = fold_clip_c;
                        if (fold_cnt_c == WINDOW_LEN) begin
                            state_d      = ST_REPORT;
                            ch1_peak_d   = fold_ch1_c;
                            ch2_peak_d   = fold_ch2_c;
                            clip_d       = fold_clip_c;
                            peak_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_ch1_peak   = ch1_peak_q;
    assign o_ch2_peak   = ch2_peak_q;
    assign o_clip       = clip_q;
    assign o_peak_valid = peak_valid_q;

endmodule

// File: doc/adc_peak_detector.md
ADC_PEAK_DETECTOR -- requirements
Module: adc_peak_detector

Interface
REQ-001 Parameter AXIS_DATA_SIZE, default 32, SHALL set the width of the incoming sample word.
REQ-002 Parameter ZMOD_DATA_SIZE, default 14, SHALL set the per-channel sample width and peak output width.
REQ-003 Parameter WINDOW_LOG2, default 10, SHALL set window length to 2**WINDOW_LOG2 valid samples.
REQ-004 One clock, i_sys_clock; reset is asynchronous and active-low, i_reset_n.
REQ-005 i_sys_clock  in  1  SHALL be the single clock; all state on rising edge.
REQ-006 i_reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 i_enable  in  1  SHALL be level-sensitive measurement enable (high = run windows).
REQ-008 i_adc_data  in  AXIS_DATA_SIZE  SHALL carry ch1 in [31:18], ch2 in [15:2], both signed two's complement.
REQ-009 i_adc_data_valid  in  1  SHALL qualify i_adc_data; no backpressure, every valid sample is consumed.
REQ-010 o_ch1_peak  out  ZMOD_DATA_SIZE  SHALL be unsigned max |ch1| of last completed window.
REQ-011 o_ch2_peak  out  ZMOD_DATA_SIZE  SHALL be unsigned max |ch2| of last completed window.
REQ-012 o_clip  out  2  SHALL flag, bit0 ch1 / bit1 ch2, any full-scale sample (+8191 or -8192) in last completed window.
REQ-013 o_peak_valid  out  1  SHALL pulse high for exactly one cycle when a window result is published.

Function
REQ-014 FSM states SHALL be IDLE, ACQUIRE, REPORT.
REQ-015 IDLE -> ACQUIRE when i_enable=1; accumulators and sample counter cleared on entry.
REQ-016 ACQUIRE: each valid sample updates running max |x| per channel, clip flags, counter +1.
REQ-017 |x| SHALL be computed in ZMOD_DATA_SIZE unsigned bits; -8192 -> 8192, no overflow.
REQ-018 ACQUIRE -> REPORT on the cycle the 2**WINDOW_LOG2-th valid sample is accepted; that sample is included.
REQ-019 Latency: outputs and o_peak_valid SHALL update on the clock edge following the last sample's acceptance cycle (1 cycle).
REQ-020 REPORT lasts one cycle, then -> ACQUIRE if i_enable=1, else -> IDLE.
REQ-021 Valid sample arriving during REPORT with i_enable=1 SHALL be the first sample of the next window (accumulators seeded with it, counter=1).
REQ-022 i_enable falling in ACQUIRE: window aborted, -> IDLE next cycle, partial results discarded, no o_peak_valid, outputs hold prior values.
REQ-023 Peak outputs and o_clip SHALL hold between reports; only updated in REPORT.
REQ-024 Counter SHALL be WINDOW_LOG2+1 bits; no wrap inside a window.
REQ-025 Cycles with i_adc_data_valid=0 SHALL not change accumulators or counter.
REQ-026 Bits [17:16] and [1:0] of i_adc_data SHALL be ignored.

Reset
REQ-027 On i_reset_n=0, asynchronously: state=IDLE, counter=0, accumulators=0, o_ch1_peak=0, o_ch2_peak=0, o_clip=2'b00, o_peak_valid=0.
REQ-028 Reset mid-window SHALL discard the window; first result after release requires a full new window.

Verification (WINDOW_LOG2=2, window=4)
REQ-029 enable=1, ch1={100,-300,50,0}, ch2={-1,2,-3,4} continuous valid -> one cycle after 4th sample o_peak_valid=1, o_ch1_peak=300, o_ch2_peak=4, o_clip=00.
REQ-030 ch1={-8192,0,0,0}, ch2={8191,0,0,0} -> o_ch1_peak=8192, o_ch2_peak=8191, o_clip=11.
REQ-031 valid toggling 1,0,1,0... over 8 cycles -> single pulse after 4th valid sample; gaps ignored.
REQ-032 back-to-back 8 valid samples, ch1 window1 max 10, window2 max 20 -> two pulses 4 cycles apart, 10 then 20; sample in REPORT cycle counted in window2.
REQ-033 enable drops after 2 samples -> no o_peak_valid, outputs keep previous values; re-enable gives a full fresh window.
REQ-034 i_reset_n asserted after 3 samples -> all outputs 0 immediately; after release 4 new samples required before pulse.
